pixel_stream_arbiter: RTL and testbench
=======================================

# pixel_stream_arbiter

- Frame-granular 2:1 round-robin arbiter for AXI-Stream pixel traffic.
- Shares the single 565→444 pixel-conversion path between two sources, e.g. a camera capture stream and a DMA framebuffer stream.
- Grants one source for a whole frame (tlast-delimited), tags each beat with its source ID, and drives a registered, backpressure-safe output stage into the converter.
- Keeps a per-source count of completed frames for software status.

## Interface
Parameters:
- DATA_W, 16, pixel word width.
- CNT_W, 16, width of the per-source frame counters.

Ports:
- aclk  in  1  single clock; everything is on its rising edge.
- aresetn  in  1  asynchronous, active-low reset.
- src_en  in  2  per-source enable; bit n gates source n. Sampled only in IDLE.
- s0_axis_tvalid / s0_axis_tready / s0_axis_tdata / s0_axis_tlast  in / out / in / in  1 / 1 / DATA_W / 1  source 0 stream.
- s1_axis_tvalid / s1_axis_tready / s1_axis_tdata / s1_axis_tlast  in / out / in / in  1 / 1 / DATA_W / 1  source 1 stream.
- m_axis_tvalid / m_axis_tready / m_axis_tdata / m_axis_tlast / m_axis_tid  out / in / out / out / out  1 / 1 / DATA_W / 1 / 1  stream to the converter; tid is the source index.
- frame_cnt0, frame_cnt1  out  CNT_W  completed frames per source.
- busy  out  1  high while any state other than IDLE is active, or while the output stage holds data.

## Operation
- States: IDLE, GRANT0, GRANT1.
- IDLE:
  - req_n = src_en[n] & sn_axis_tvalid.
  - Only one requester: go to that source's GRANTn.
  - Both requesting: grant the source other than rr_last.
  - No requester: stay in IDLE.
  - The grant decision is registered; no beat is accepted in the IDLE cycle.
- GRANTn:
  - sn_axis_tready = ~skid_valid. The other source's tready = 0.
  - An accepted beat (valid & ready) is pushed into the output stage with tid = n.
  - An accepted beat with tlast=1: next state IDLE, rr_last <= n, frame_cntn <= frame_cntn + 1.
  - The counter wraps modulo 2^CNT_W.
- src_en deasserting mid-frame does not abort the frame. The frame completes, and the source is then excluded at the next IDLE.
- Output stage: a 2-entry skid buffer (main register plus skid register).
  - m_axis_* are driven from the main register only.
  - When the main register is full and m_axis_tready=0, an incoming beat lands in the skid register.
  - Upstream tready is deasserted while the skid register is valid.
  - No beat is ever dropped or duplicated. tdata, tlast and tid are held stable while tvalid=1 and tready=0.
- rr_last reset value is 1, so source 0 wins the first contention.

## Timing
- Reset values (asynchronous): state=IDLE, rr_last=1, all tready=0, m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, m_axis_tid=0, skid_valid=0, frame_cnt0=frame_cnt1=0, busy=0.
- Latency: a beat accepted at input edge k appears on m_axis at edge k+1 (m_axis_tvalid=1), provided the output stage was empty.
- Grant latency: a request in IDLE at edge k means tready=1 from edge k+1.
- Frame switch costs exactly one IDLE bubble cycle after the tlast beat is accepted. Sustained throughput with both sources active is N/(N+1) for N-beat frames.
- With m_axis_tready held 1, input throughput within a frame is 1 beat/cycle.
- tlast accepted in the same cycle as a new request from the other source: the other source is granted at the next IDLE evaluation, with no extra bubble beyond the one IDLE cycle.
- Reset mid-frame: the partial frame and buffered beats are discarded, m_axis_tvalid drops immediately, and counters clear.

## Structure
- Package pixel_arb_pkg holds:
  - the state enum (IDLE, GRANT0, GRANT1);
  - the source-ID constants SRC_CAM=0 and SRC_DMA=1;
  - the DATA_W default.
- One sub-module: axis_skid_buffer, a 2-entry registered slice carrying {tid, tlast, tdata}. It is reused for other stream paths.
- The top level contains the FSM, the round-robin pointer, the input mux and the counters.

## Test plan
- Single source: src_en=2'b01, s0 sends a 4-beat frame 0xF800, 0x07E0, 0x001F, 0xFFFF (tlast on beat 4), m_axis_tready=1.
  - m_axis shows the same 4 beats with tid=0 and tlast on beat 4; frame_cnt0=1.
- Contention: both sources enabled with continuous 3-beat frames.
  - Output frames alternate tid 0,1,0,1, starting with tid 0 after reset.
  - Exactly one bubble cycle between frames.
  - After 4 frames, frame_cnt0=2 and frame_cnt1=2.
- Backpressure: m_axis_tready toggles 1,0,0,1 during an 8-beat frame.
  - All 8 beats arrive in order, none lost or duplicated.
  - Output is held stable while stalled.
  - Input tready drops only while the skid register is full.
- Enable change: src_en[1] cleared mid-frame on s1.
  - The frame completes.
  - Subsequent s1 requests are ignored; s0 is served exclusively.
- Counter wrap: CNT_W=4, 17 single-beat frames on s0 → frame_cnt0=1.
- Reset mid-frame: aresetn pulsed low at beat 2 of a 5-beat frame.
  - All outputs return to their reset values in the same cycle.
  - After release, a new frame passes intact with counters restarted from 0.

Source files
------------

// File: rtl/pixel_arb_pkg.sv
// Shared types and constants for the pixel stream arbiter slice.
package pixel_arb_pkg;

  localparam int unsigned DATA_W_DEF = 16;

  // Source IDs carried on m_axis_tid
  localparam logic SRC_CAM = 1'b0;
  localparam logic SRC_DMA = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } arb_state_e;

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry registered stream slice: outputs come from the main register only,
// and a second skid register absorbs one beat while downstream stalls.
module axis_skid_buffer #(
  parameter int unsigned W = 18
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         s_valid_i,
  output logic         s_ready_o,
  input  logic [W-1:0] s_data_i,
  output logic         m_valid_o,
  input  logic         m_ready_i,
  output logic [W-1:0] m_data_o,
  output logic         busy_o
);

  logic         main_valid_q, main_valid_d;
  logic         skid_valid_q, skid_valid_d;
  logic [W-1:0] main_data_q, main_data_d;
  logic [W-1:0] skid_data_q, skid_data_d;
  logic         push;

  assign s_ready_o = ~skid_valid_q;
  assign push      = s_valid_i & ~skid_valid_q;

  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (~main_valid_q | m_ready_i) begin
      // Main register frees up: the skid beat is older, so it moves first.
      if (skid_valid_q) begin
        main_valid_d = 1'b1;
        main_data_d  = skid_data_q;
        skid_valid_d = 1'b0;
      end else begin
        main_valid_d = push;
        if (push) main_data_d = s_data_i;
      end
    end else if (push) begin
      skid_valid_d = 1'b1;
      skid_data_d  = s_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      main_data_q  <= '0;
      skid_data_q  <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      main_data_q  <= main_data_d;
      skid_data_q  <= skid_data_d;
    end
  end

  assign m_valid_o = main_valid_q;
  assign m_data_o  = main_data_q;
  assign busy_o    = main_valid_q | skid_valid_q;

endmodule

// File: rtl/pixel_stream_arbiter.sv
// Frame-granular 2:1 round-robin arbiter feeding the shared 565->444 converter,
// with per-source completed-frame counters.
module pixel_stream_arbiter
  import pixel_arb_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic [1:0]        src_en,
  input  logic              s0_axis_tvalid,
  output logic              s0_axis_tready,
  input  logic [DATA_W-1:0] s0_axis_tdata,
  input  logic              s0_axis_tlast,
  input  logic              s1_axis_tvalid,
  output logic              s1_axis_tready,
  input  logic [DATA_W-1:0] s1_axis_tdata,
  input  logic              s1_axis_tlast,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tlast,
  output logic              m_axis_tid,
  output logic [CNT_W-1:0]  frame_cnt0,
  output logic [CNT_W-1:0]  frame_cnt1,
  output logic              busy
);

  localparam int unsigned BUF_W = DATA_W + 2;

  arb_state_e        state_q, state_d;
  logic              rr_last_q, rr_last_d;
  logic [CNT_W-1:0]  cnt0_q, cnt0_d, cnt1_q, cnt1_d;

  logic              req0, req1;
  logic              push_valid, push_last, push_tid;
  logic [DATA_W-1:0] push_data;
  logic              buf_ready, buf_busy;
  logic [BUF_W-1:0]  buf_out;

  assign req0 = src_en[0] & s0_axis_tvalid;
  assign req1 = src_en[1] & s1_axis_tvalid;

  always_comb begin
    state_d        = state_q;
    rr_last_d      = rr_last_q;
    cnt0_d         = cnt0_q;
    cnt1_d         = cnt1_q;
    s0_axis_tready = 1'b0;
    s1_axis_tready = 1'b0;
    push_valid     = 1'b0;
    push_tid       = SRC_CAM;
    push_data      = s0_axis_tdata;
    push_last      = s0_axis_tlast;
    case (state_q)
      IDLE: begin
        if (req0 && req1)  state_d = (rr_last_q == SRC_DMA) ? GRANT0 : GRANT1;
        else if (req0)     state_d = GRANT0;
        else if (req1)     state_d = GRANT1;
      end
      GRANT0: begin
        s0_axis_tready = buf_ready;
        push_valid     = s0_axis_tvalid & buf_ready;
        if (push_valid && s0_axis_tlast) begin
          state_d   = IDLE;
          rr_last_d = SRC_CAM;
          cnt0_d    = cnt0_q + CNT_W'(1);
        end
      end
      GRANT1: begin
        s1_axis_tready = buf_ready;
        push_valid     = s1_axis_tvalid & buf_ready;
        push_tid       = SRC_DMA;
        push_data      = s1_axis_tdata;
        push_last      = s1_axis_tlast;
        if (push_valid && s1_axis_tlast) begin
          state_d   = IDLE;
          rr_last_d = SRC_DMA;
          cnt1_d    = cnt1_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= IDLE;
      rr_last_q <= SRC_DMA;
      cnt0_q    <= '0;
      cnt1_q    <= '0;
    end else begin
      state_q   <= state_d;
      rr_last_q <= rr_last_d;
      cnt0_q    <= cnt0_d;
      cnt1_q    <= cnt1_d;
    end
  end

  axis_skid_buffer #(
    .W (BUF_W)
  ) u_out_slice (
    .clk_i     (aclk),
    .rst_ni    (aresetn),
    .s_valid_i (push_valid),
    .s_ready_o (buf_ready),
    .s_data_i  ({push_tid, push_last, push_data}),
    .m_valid_o (m_axis_tvalid),
    .m_ready_i (m_axis_tready),
    .m_data_o  (buf_out),
    .busy_o    (buf_busy)
  );

  assign m_axis_tdata = buf_out[DATA_W-1:0];
  assign m_axis_tlast = buf_out[DATA_W];
  assign m_axis_tid   = buf_out[DATA_W+1];
  assign frame_cnt0   = cnt0_q;
  assign frame_cnt1   = cnt1_q;
  assign busy         = (state_q != IDLE) | buf_busy;

endmodule

// File: tb/tb_pixel_stream_arbiter.sv
// Directed self-checking bench for pixel_stream_arbiter.
module tb_pixel_stream_arbiter;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [1:0]  src_en = 2'b00;
  logic        s0_tvalid = 1'b0, s0_tlast = 1'b0, s1_tvalid = 1'b0, s1_tlast = 1'b0;
  logic [15:0] s0_tdata = '0, s1_tdata = '0;
  logic        s0_tready, s1_tready;
  logic        m_tvalid, m_tlast, m_tid, busy;
  logic        m_tready = 1'b0;
  logic [15:0] m_tdata, cnt0, cnt1;

  logic        w_s0_tready, w_s1_tready, w_m_tvalid, w_m_tlast, w_m_tid, w_busy;
  logic [15:0] w_m_tdata;
  logic [3:0]  w_cnt0, w_cnt1;

  always #5 aclk = ~aclk;

  pixel_stream_arbiter #(.DATA_W(16), .CNT_W(16)) dut (
    .aclk(aclk), .aresetn(aresetn), .src_en(src_en),
    .s0_axis_tvalid(s0_tvalid), .s0_axis_tready(s0_tready), .s0_axis_tdata(s0_tdata), .s0_axis_tlast(s0_tlast),
    .s1_axis_tvalid(s1_tvalid), .s1_axis_tready(s1_tready), .s1_axis_tdata(s1_tdata), .s1_axis_tlast(s1_tlast),
    .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_tdata(m_tdata), .m_axis_tlast(m_tlast),
    .m_axis_tid(m_tid), .frame_cnt0(cnt0), .frame_cnt1(cnt1), .busy(busy)
  );

  // Narrow-counter instance shares all inputs so its counter wraps at 16.
  pixel_stream_arbiter #(.DATA_W(16), .CNT_W(4)) dut_w (
    .aclk(aclk), .aresetn(aresetn), .src_en(src_en),
    .s0_axis_tvalid(s0_tvalid), .s0_axis_tready(w_s0_tready), .s0_axis_tdata(s0_tdata), .s0_axis_tlast(s0_tlast),
    .s1_axis_tvalid(s1_tvalid), .s1_axis_tready(w_s1_tready), .s1_axis_tdata(s1_tdata), .s1_axis_tlast(s1_tlast),
    .m_axis_tvalid(w_m_tvalid), .m_axis_tready(m_tready), .m_axis_tdata(w_m_tdata), .m_axis_tlast(w_m_tlast),
    .m_axis_tid(w_m_tid), .frame_cnt0(w_cnt0), .frame_cnt1(w_cnt1), .busy(w_busy)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    int          cyc;
    logic        tid;
    logic        last;
    logic [15:0] data;
  } beat_t;

  beat_t       obs[$];
  logic        prev_stall = 1'b0;
  logic [17:0] prev_word = '0;
  bit          bp_win = 1'b0;
  int          bp_in = 0, bp_out = 0;

  always @(negedge aclk) begin
    cyc++;
    if (aresetn !== 1'b1) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", m_tvalid, 1);
        chk("hold_word", {m_tid, m_tlast, m_tdata}, prev_word);
      end
      if (bp_win && bp_in > 0 && bp_in < 8)
        chk("bp_in_ready", s0_tready, (bp_in - bp_out) < 2);
      if (bp_win) begin
        if (s0_tvalid && s0_tready) bp_in++;
        if (m_tvalid && m_tready) bp_out++;
      end
      if (m_tvalid && m_tready) obs.push_back('{cyc, m_tid, m_tlast, m_tdata});
      prev_stall = m_tvalid & ~m_tready;
      prev_word  = {m_tid, m_tlast, m_tdata};
    end
  end

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic do_reset();
    aresetn   = 1'b0;
    s0_tvalid = 1'b0; s0_tlast = 1'b0;
    s1_tvalid = 1'b0; s1_tlast = 1'b0;
    step();
    step();
    aresetn = 1'b1;
    obs.delete();
  endtask

  task automatic beat(input int src, input logic [15:0] d, input logic l);
    bit hs;
    hs = 1'b0;
    if (src == 0) begin s0_tvalid = 1'b1; s0_tdata = d; s0_tlast = l; end
    else          begin s1_tvalid = 1'b1; s1_tdata = d; s1_tlast = l; end
    for (int i = 0; i < 64 && !hs; i++) begin
      @(negedge aclk);
      hs = (src == 0) ? s0_tready : s1_tready;
      step();
    end
    chk((src == 0) ? "s0_handshake" : "s1_handshake", hs, 1);
  endtask

  task automatic frame(input int src, input logic [15:0] base, input int n, input bit keep);
    for (int b = 0; b < n; b++) beat(src, base + 16'(b), b == n - 1);
    if (!keep) begin
      if (src == 0) begin s0_tvalid = 1'b0; s0_tlast = 1'b0; end
      else          begin s1_tvalid = 1'b0; s1_tlast = 1'b0; end
    end
  endtask

  task automatic check_beat(input string t, input int i, input logic tid, input logic last,
                            input logic [15:0] data);
    if (i < obs.size()) begin
      chk($sformatf("%s_b%0d_tid", t, i), obs[i].tid, tid);
      chk($sformatf("%s_b%0d_last", t, i), obs[i].last, last);
      chk($sformatf("%s_b%0d_data", t, i), obs[i].data, data);
    end else begin
      chk($sformatf("%s_b%0d_missing", t, i), obs.size(), i + 1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] exp_d;
    aresetn = 1'b1;
    #1 aresetn = 1'b0;
    #2;
    chk("rst_m_tvalid", m_tvalid, 0);
    chk("rst_m_tdata", m_tdata, 0);
    chk("rst_m_tlast", m_tlast, 0);
    chk("rst_m_tid", m_tid, 0);
    chk("rst_s0_tready", s0_tready, 0);
    chk("rst_s1_tready", s1_tready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cnt0", cnt0, 0);
    chk("rst_cnt1", cnt1, 0);
    chk("rst_w_m_tvalid", w_m_tvalid, 0);
    chk("rst_w_cnt0", w_cnt0, 0);

    // Single source, cycle-exact latency
    src_en = 2'b01; m_tready = 1'b1;
    step(); step();
    aresetn = 1'b1;
    step();
    s0_tvalid = 1'b1; s0_tdata = 16'hF800; s0_tlast = 1'b0;
    chk("t1_idle_ready", s0_tready, 0);
    step();
    chk("t1_grant_ready", s0_tready, 1);
    chk("t1_no_out_yet", m_tvalid, 0);
    chk("t1_busy", busy, 1);
    step();
    chk("t1_v0", m_tvalid, 1); chk("t1_d0", m_tdata, 16'hF800);
    chk("t1_id0", m_tid, 0);   chk("t1_l0", m_tlast, 0);
    s0_tdata = 16'h07E0;
    step();
    chk("t1_v1", m_tvalid, 1); chk("t1_d1", m_tdata, 16'h07E0);
    s0_tdata = 16'h001F;
    step();
    chk("t1_v2", m_tvalid, 1); chk("t1_d2", m_tdata, 16'h001F);
    s0_tdata = 16'hFFFF; s0_tlast = 1'b1;
    step();
    chk("t1_v3", m_tvalid, 1); chk("t1_d3", m_tdata, 16'hFFFF);
    chk("t1_l3", m_tlast, 1);  chk("t1_id3", m_tid, 0);
    chk("t1_cnt0", cnt0, 1);   chk("t1_ready_after_last", s0_tready, 0);
    chk("t1_busy_draining", busy, 1);
    s0_tvalid = 1'b0; s0_tlast = 1'b0;
    step();
    chk("t1_drained", m_tvalid, 0);
    chk("t1_idle_busy", busy, 0);

    // Contention: alternating 3-beat frames, one bubble between frames
    do_reset();
    src_en = 2'b11; m_tready = 1'b1;
    fork
      begin frame(0, 16'hA000, 3, 1'b1); frame(0, 16'hA010, 3, 1'b0); end
      begin frame(1, 16'hB000, 3, 1'b1); frame(1, 16'hB010, 3, 1'b0); end
    join
    step(); step();
    chk("t2_count", obs.size(), 12);
    for (int i = 0; i < 12; i++) begin
      exp_d = ((i / 3) % 2 == 1) ? 16'hB000 : 16'hA000;
      exp_d = exp_d + 16'((i / 6) * 16) + 16'(i % 3);
      check_beat("t2", i, logic'((i / 3) % 2), i % 3 == 2, exp_d);
      if (i > 0 && i < obs.size())
        chk($sformatf("t2_gap%0d", i), obs[i].cyc - obs[i-1].cyc, (i % 3 == 0) ? 2 : 1);
    end
    chk("t2_cnt0", cnt0, 2);
    chk("t2_cnt1", cnt1, 2);

    // Backpressure: m_axis_tready pattern 1,0,0,1 over an 8-beat frame
    do_reset();
    src_en = 2'b01; m_tready = 1'b1;
    bp_in = 0; bp_out = 0; bp_win = 1'b1;
    fork
      frame(0, 16'hC000, 8, 1'b0);
      for (int i = 0; i < 40; i++) begin
        m_tready = (i % 4 == 0) || (i % 4 == 3);
        step();
      end
    join
    m_tready = 1'b1;
    step(); step();
    bp_win = 1'b0;
    chk("t3_count", obs.size(), 8);
    for (int i = 0; i < 8; i++) check_beat("t3", i, 1'b0, i == 7, 16'hC000 + 16'(i));
    chk("t3_out_beats", bp_out, 8);
    chk("t3_cnt0", cnt0, 1);

    // Enable change: s1 disabled mid-frame, frame completes, s1 then ignored
    do_reset();
    src_en = 2'b11; m_tready = 1'b1;
    beat(1, 16'hD000, 1'b0);
    beat(1, 16'hD001, 1'b0);
    src_en = 2'b01;
    beat(1, 16'hD002, 1'b0);
    beat(1, 16'hD003, 1'b1);
    s1_tvalid = 1'b1; s1_tdata = 16'hDEAD; s1_tlast = 1'b1;
    frame(0, 16'hE000, 2, 1'b1);
    frame(0, 16'hE010, 2, 1'b0);
    step(); step(); step();
    chk("t4_s1_ready", s1_tready, 0);
    chk("t4_count", obs.size(), 8);
    for (int i = 0; i < 4; i++) check_beat("t4", i, 1'b1, i == 3, 16'hD000 + 16'(i));
    check_beat("t4", 4, 1'b0, 1'b0, 16'hE000);
    check_beat("t4", 5, 1'b0, 1'b1, 16'hE001);
    check_beat("t4", 6, 1'b0, 1'b0, 16'hE010);
    check_beat("t4", 7, 1'b0, 1'b1, 16'hE011);
    chk("t4_cnt0", cnt0, 2);
    chk("t4_cnt1", cnt1, 1);
    s1_tvalid = 1'b0; s1_tlast = 1'b0;

    // Counter wrap: 17 single-beat frames
    do_reset();
    src_en = 2'b01; m_tready = 1'b1;
    for (int i = 0; i < 17; i++) beat(0, 16'h0100 + 16'(i), 1'b1);
    s0_tvalid = 1'b0; s0_tlast = 1'b0;
    step(); step();
    chk("t5_count", obs.size(), 17);
    chk("t5_cnt0_wide", cnt0, 17);
    chk("t5_cnt0_wrap", w_cnt0, 1);
    chk("t5_cnt1", cnt1, 0);

    // Reset mid-frame at beat 2 of a 5-beat frame
    beat(0, 16'hF000, 1'b0);
    beat(0, 16'hF001, 1'b0);
    chk("t6_pre_valid", m_tvalid, 1);
    chk("t6_pre_data", m_tdata, 16'hF001);
    aresetn = 1'b0;
    #1;
    chk("t6_m_tvalid", m_tvalid, 0);
    chk("t6_m_tdata", m_tdata, 0);
    chk("t6_m_tlast", m_tlast, 0);
    chk("t6_m_tid", m_tid, 0);
    chk("t6_s0_tready", s0_tready, 0);
    chk("t6_busy", busy, 0);
    chk("t6_cnt0", cnt0, 0);
    chk("t6_w_cnt0", w_cnt0, 0);
    s0_tvalid = 1'b0; s0_tlast = 1'b0;
    step(); step();
    aresetn = 1'b1;
    obs.delete();
    frame(0, 16'h1230, 2, 1'b0);
    step(); step();
    chk("t6_count", obs.size(), 2);
    check_beat("t6", 0, 1'b0, 1'b0, 16'h1230);
    check_beat("t6", 1, 1'b0, 1'b1, 16'h1231);
    chk("t6_cnt0_restart", cnt0, 1);
    chk("t6_w_cnt0_restart", w_cnt0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
